// File: rtl/uart_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_arbiter
// Brief    : Round-robin arbiter sharing one memory port between the UART
//            monitor (M) and the CPU data bus (C), with a hung-memory timeout.
// Revision : 1.0
// ============================================================================
module uart_mem_arbiter #(
  parameter int          TMO_W     = 8,
  parameter logic [31:0] TMO_RDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  // monitor requester
  input  logic        m_req,
  input  logic        m_we,
  input  logic [31:0] m_adr,
  input  logic [31:0] m_wdata,
  output logic        m_done,
  output logic [31:0] m_rdata,
  // CPU requester
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_adr,
  input  logic [31:0] c_wdata,
  output logic        c_done,
  output logic [31:0] c_rdata,
  // memory side
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  // status
  output logic        tmo_err,
  output logic        owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The counter is compared one short of all-ones so that the cycle in which
  // it saturates is also the last cycle mem_req is seen high.
  localparam logic [TMO_W-1:0] c_tmo_pre_sat = {TMO_W{1'b1}} - TMO_W'(1);

  state_t             r_state;
  logic               r_last_grant;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic               r_owner;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [31:0]        r_mem_adr;
  logic [31:0]        r_mem_wdata;
  logic               r_m_done;
  logic               r_c_done;
  logic [31:0]        r_m_rdata;
  logic [31:0]        r_c_rdata;
  logic               r_tmo_err;

  logic               w_any_req;
  logic               w_grant_c;
  logic               w_tmo_hit;
  logic               w_complete;
  logic [31:0]        w_cpl_rdata;

  assign w_any_req   = m_req | c_req;
  // On a tie the requester that did not win last time is served.
  assign w_grant_c   = (m_req & c_req) ? ~r_last_grant : c_req;
  assign w_tmo_hit   = (r_tmo_cnt == c_tmo_pre_sat);
  assign w_complete  = mem_ack | w_tmo_hit;
  assign w_cpl_rdata = mem_ack ? mem_rdata : TMO_RDATA;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_tmo_cnt    <= '0;
      r_owner      <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_adr    <= '0;
      r_mem_wdata  <= '0;
      r_m_done     <= 1'b0;
      r_c_done     <= 1'b0;
      r_m_rdata    <= '0;
      r_c_rdata    <= '0;
      r_tmo_err    <= 1'b0;
    end else begin
      r_m_done  <= 1'b0;
      r_c_done  <= 1'b0;
      r_tmo_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tmo_cnt <= '0;
          if (w_any_req) begin
            r_owner     <= w_grant_c;
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_grant_c ? c_we    : m_we;
            r_mem_adr   <= w_grant_c ? c_adr   : m_adr;
            r_mem_wdata <= w_grant_c ? c_wdata : m_wdata;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_complete) begin
            r_mem_req    <= 1'b0;
            r_last_grant <= r_owner;
            // A real ack in the saturating cycle wins over the timeout.
            r_tmo_err    <= ~mem_ack;
            if (r_owner) begin
              r_c_done <= 1'b1;
              if (!r_mem_we) r_c_rdata <= w_cpl_rdata;
            end else begin
              r_m_done <= 1'b1;
              if (!r_mem_we) r_m_rdata <= w_cpl_rdata;
            end
            r_state <= S_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_tmo_cnt <= '0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m_done    = r_m_done;
  assign m_rdata   = r_m_rdata;
  assign c_done    = r_c_done;
  assign c_rdata   = r_c_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_adr   = r_mem_adr;
  assign mem_wdata = r_mem_wdata;
  assign tmo_err   = r_tmo_err;
  assign owner     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mem_arbiter
// Brief    : Directed self-checking bench for uart_mem_arbiter (TMO_W = 3).
// Revision : 1.0
// ============================================================================
module tb_uart_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_req, m_we, c_req, c_we;
  logic [31:0] m_adr, m_wdata, c_adr, c_wdata;
  logic        m_done, c_done;
  logic [31:0] m_rdata, c_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic        tmo_err, owner;

  int checks   = 0;
  int failures = 0;

  uart_mem_arbiter #(
    .TMO_W     (3),
    .TMO_RDATA (32'hDEADBEEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_adr     (m_adr),
    .m_wdata   (m_wdata),
    .m_done    (m_done),
    .m_rdata   (m_rdata),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_adr     (c_adr),
    .c_wdata   (c_wdata),
    .c_done    (c_done),
    .c_rdata   (c_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .tmo_err   (tmo_err),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    m_req = 0; m_we = 0; m_adr = '0; m_wdata = '0;
    c_req = 0; c_we = 0; c_adr = '0; c_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    step();
    step();
    check("rst_mem_req", mem_req, 0);
    check("rst_m_done", m_done, 0);
    check("rst_c_done", c_done, 0);
    check("rst_tmo_err", tmo_err, 0);
    check("rst_owner", owner, 0);
    check("rst_mem_adr", mem_adr, 0);
    check("rst_m_rdata", m_rdata, 0);
    check("rst_c_rdata", c_rdata, 0);
    rst = 1'b0;

    // Stray ack while idle must be ignored.
    mem_ack = 1; mem_rdata = 32'h7777_7777;
    step();
    mem_ack = 0;
    check("idle_ack_mem_req", mem_req, 0);
    check("idle_ack_m_done", m_done, 0);
    check("idle_ack_c_done", c_done, 0);
    step();

    // ---- Single monitor read ----
    m_req = 1; m_we = 0; m_adr = 32'h0000_0010;
    step();                                   // cycle 1
    check("rd_mem_req_c1", mem_req, 1);
    check("rd_mem_we", mem_we, 0);
    check("rd_mem_adr", mem_adr, 32'h10);
    check("rd_owner", owner, 0);
    step();                                   // cycle 2
    check("rd_mem_req_c2", mem_req, 1);
    step();                                   // cycle 3
    check("rd_mem_req_c3", mem_req, 1);
    check("rd_no_early_done", m_done, 0);
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    step();                                   // cycle 4
    mem_ack = 0;
    check("rd_m_done", m_done, 1);
    check("rd_m_rdata", m_rdata, 32'h1234_5678);
    check("rd_c_done", c_done, 0);
    check("rd_mem_req_low", mem_req, 0);
    check("rd_tmo_err", tmo_err, 0);
    m_req = 0;
    step();
    check("rd_done_width", m_done, 0);
    check("rd_rdata_held", m_rdata, 32'h1234_5678);

    // ---- Single CPU write; requester inputs change mid-BUSY ----
    c_req = 1; c_we = 1; c_adr = 32'h40; c_wdata = 32'hA5A5_0001;
    step();
    check("wr_mem_req", mem_req, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_adr", mem_adr, 32'h40);
    check("wr_mem_wdata", mem_wdata, 32'hA5A5_0001);
    check("wr_owner", owner, 1);
    c_adr = 32'hFFFF_FFF0; c_wdata = 32'h0; c_we = 0;
    step();
    check("wr_adr_held", mem_adr, 32'h40);
    check("wr_wdata_held", mem_wdata, 32'hA5A5_0001);
    check("wr_we_held", mem_we, 1);
    mem_ack = 1; mem_rdata = 32'hFFFF_0000;
    step();
    mem_ack = 0;
    check("wr_c_done", c_done, 1);
    check("wr_m_done", m_done, 0);
    check("wr_c_rdata_kept", c_rdata, 32'h0);
    c_req = 0;
    step();
    check("wr_done_width", c_done, 0);

    // ---- Contention: grants must alternate M, C, M, C ----
    m_req = 1; m_we = 0; m_adr = 32'h100;
    c_req = 1; c_we = 0; c_adr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      step();                                 // grant
      check("ct_mem_req", mem_req, 1);
      check("ct_owner", owner, (i % 2 == 1) ? 32'd1 : 32'd0);
      check("ct_mem_adr", mem_adr, (i % 2 == 1) ? 32'h200 : 32'h100);
      step();
      step();
      mem_ack = 1; mem_rdata = 32'h1000 + i;
      step();
      mem_ack = 0;
      check("ct_m_done", m_done, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("ct_c_done", c_done, (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
      check("ct_done_width", m_done | c_done, 0);
    end
    m_req = 0; c_req = 0;
    check("ct_m_rdata", m_rdata, 32'h1002);
    check("ct_c_rdata", c_rdata, 32'h1003);
    step();

    // ---- Timeout: mem_ack never arrives ----
    m_req = 1; m_we = 0; m_adr = 32'h20;
    step();                                   // BUSY cycle 1
    check("to_mem_req_c1", mem_req, 1);
    for (int k = 2; k <= 7; k++) begin
      step();
      check("to_mem_req_held", mem_req, 1);
      check("to_no_early_done", m_done, 0);
    end
    step();                                   // cycle 8
    check("to_mem_req_low", mem_req, 0);
    check("to_m_done", m_done, 1);
    check("to_tmo_err", tmo_err, 1);
    check("to_m_rdata", m_rdata, 32'hDEADBEEF);
    m_req = 0;
    step();
    check("to_tmo_err_width", tmo_err, 0);
    c_req = 1; c_we = 0; c_adr = 32'h44;
    step();
    check("to_next_grant", mem_req, 1);
    check("to_next_owner", owner, 1);
    step();
    mem_ack = 1; mem_rdata = 32'hCAFE_0001;
    step();
    mem_ack = 0;
    check("to_next_c_done", c_done, 1);
    check("to_next_c_rdata", c_rdata, 32'hCAFE_0001);
    check("to_next_tmo_err", tmo_err, 0);
    c_req = 0;
    step();

    // ---- Ack in the saturating (7th) BUSY cycle wins ----
    m_req = 1; m_we = 0; m_adr = 32'h24;
    step();                                   // BUSY cycle 1
    for (int k = 2; k <= 7; k++) step();
    check("sat_mem_req_c7", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ack = 0;
    check("sat_m_done", m_done, 1);
    check("sat_tmo_err", tmo_err, 0);
    check("sat_m_rdata", m_rdata, 32'h0BAD_F00D);
    m_req = 0;
    step();

    // ---- Reset in the middle of BUSY ----
    m_req = 1; m_we = 0; m_adr = 32'h30;
    step();                                   // BUSY cycle 1
    step();                                   // BUSY cycle 2
    rst = 1;
    mem_ack = 1; mem_rdata = 32'h5555_AAAA;
    step();
    rst = 0; mem_ack = 0;
    check("rb_mem_req", mem_req, 0);
    check("rb_m_done", m_done, 0);
    check("rb_tmo_err", tmo_err, 0);
    check("rb_m_rdata", m_rdata, 32'h0);
    m_req = 1; m_adr = 32'h34;
    c_req = 1; c_we = 0; c_adr = 32'h38;
    step();
    check("rb_regrant_req", mem_req, 1);
    check("rb_regrant_owner", owner, 0);
    check("rb_regrant_adr", mem_adr, 32'h34);
    check("rb_no_stale_done", m_done | c_done, 0);
    mem_ack = 1; mem_rdata = 32'h0000_0BB1;
    step();
    mem_ack = 0;
    check("rb_m_done", m_done, 1);
    check("rb_rdata", m_rdata, 32'h0000_0BB1);
    m_req = 0; c_req = 0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
